// File: rtl/types_pkg.sv
// Shared fetch-stage types: reset PC, FIFO entry layout, PC step helper.
// No logic; constants and typedefs only.
// Not applicable; nothing here carries flow control.
package types_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry;

  // Sequential fetch advances one 32-bit word; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundles the instruction-memory port, back-end redirect and decode handshake.
// Pure wiring; no latency.
// Decode backpressure is ready_out; fetch throttles imem_req from it.
interface fetch_if;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  // Fetch stage side.
  modport master (
    input  mispredict, redirect_pc, imem_rdata, ready_out,
    output imem_req, imem_addr, valid_out, instr_out, pc_out
  );

  // Environment side: back end, instruction memory and decode.
  modport slave (
    output mispredict, redirect_pc, imem_rdata, ready_out,
    input  imem_req, imem_addr, valid_out, instr_out, pc_out
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of {pc, instr} with flush; head is a register read.
// Push visible at head the cycle after the push edge.
// No internal backpressure; the caller must never push when full.
module fetch_buffer
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  fetch_entry push_dat_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output fetch_entry head_dat_o,
  output logic [1:0] count_o
);

  fetch_entry entries_q [2];
  fetch_entry entries_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  // Next state: flush wins over push and pop; 1-bit pointers wrap naturally.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        entries_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // State registers; reset also clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head_dat_o = entries_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC generation, single-cycle imem request, 2-entry output FIFO.
// Request at T, data at T+1, valid_out at T+2; redirect to valid_out is 3 cycles.
// Requests stall when buffered + in-flight entries would exceed 2; decode stalls hold the head.
module fetch #(
  parameter logic [31:0] RESET_PC = types_pkg::RESET_PC
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  import types_pkg::fetch_entry;
  import types_pkg::next_pc;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;

  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop;
  logic        push;
  fetch_entry  head;
  fetch_entry  push_entry;

  // Handshake and request decision; a redirect or reset suppresses everything.
  always_comb begin
    bus.valid_out = (count != 2'd0) && !bus.mispredict && !reset;
    pop           = bus.valid_out && bus.ready_out;
    occupancy     = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    bus.imem_req  = !reset && !bus.mispredict && (occupancy < 3'd2);
    push          = inflight_q && !bus.mispredict && !reset;
    push_entry    = '{pc: req_pc_q, instr: bus.imem_rdata};
  end

  // PC and in-flight tracking; redirect overrides the sequential increment.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = bus.imem_req;
    if (bus.mispredict) begin
      pc_d = bus.redirect_pc;
    end else if (bus.imem_req) begin
      pc_d     = next_pc(pc_q);
      req_pc_d = pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .flush_i    (bus.mispredict),
    .head_dat_o (head),
    .count_o    (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.instr_out = head.instr;
  assign bus.pc_out    = head.pc;

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  logic clk;
  logic reset;
  fetch_if bus ();

  fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: returns 32'hA0 + address one cycle after the request.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'hA0 + bus.imem_addr;
  end

  typedef struct {
    logic        rst;
    logic        mp;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic        chk_dat;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  int n_checks;
  int n_errors;
  vec_t vecs [35];

  function automatic vec_t mk(logic rst, logic mp, logic [31:0] rpc, logic rdy,
                              logic e_req, logic [31:0] e_addr, logic e_vld,
                              logic chk_dat, logic [31:0] e_pc, logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.mp = mp; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.chk_dat = chk_dat; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.mispredict = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.ready_out = 1'b1;
    bus.imem_rdata = 32'h0;

    //            rst mp  rpc           rdy req addr          vld cd  pc            instr
    vecs[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h0,        32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0,        32'h0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 1, 32'h4,        0, 0, 32'h0,        32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 0, 32'h0,        32'hA0);
    vecs[5]  = mk(0, 0, 32'h0,        1, 1, 32'hC,        1, 0, 32'h4,        32'hA4);
    vecs[6]  = mk(0, 0, 32'h0,        1, 1, 32'h10,       1, 0, 32'h8,        32'hA8);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hAC);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hAC);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hAC);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hAC);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hAC);
    vecs[12] = mk(0, 0, 32'h0,        1, 1, 32'h14,       1, 0, 32'hC,        32'hAC);
    vecs[13] = mk(0, 0, 32'h0,        1, 1, 32'h18,       1, 0, 32'h10,       32'hB0);
    vecs[14] = mk(0, 0, 32'h0,        1, 1, 32'h1C,       1, 0, 32'h14,       32'hB4);
    vecs[15] = mk(0, 1, 32'h100,      1, 0, 32'h0,        0, 0, 32'h0,        32'h0);
    vecs[16] = mk(0, 0, 32'h0,        1, 1, 32'h100,      0, 0, 32'h0,        32'h0);
    vecs[17] = mk(0, 0, 32'h0,        1, 1, 32'h104,      0, 0, 32'h0,        32'h0);
    vecs[18] = mk(0, 0, 32'h0,        1, 1, 32'h108,      1, 0, 32'h100,      32'h1A0);
    vecs[19] = mk(0, 0, 32'h0,        1, 1, 32'h10C,      1, 0, 32'h104,      32'h1A4);
    vecs[20] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,       0, 0, 32'h0,        32'h0);
    vecs[21] = mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0);
    vecs[22] = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 0, 32'h0,        32'h0);
    vecs[23] = mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 0, 32'hFFFF_FFFC, 32'h9C);
    vecs[24] = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 0, 32'h0,        32'hA0);
    vecs[25] = mk(0, 0, 32'h0,        1, 1, 32'hC,        1, 0, 32'h4,        32'hA4);
    vecs[26] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h8,        32'hA8);
    vecs[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h8,        32'hA8);
    vecs[28] = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        32'h0);
    vecs[29] = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0,        32'h0);
    vecs[30] = mk(0, 0, 32'h0,        1, 1, 32'h4,        0, 0, 32'h0,        32'h0);
    vecs[31] = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 0, 32'h0,        32'hA0);
    vecs[32] = mk(1, 1, 32'h200,      1, 0, 32'h0,        0, 0, 32'h0,        32'h0);
    vecs[33] = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0,        32'h0);
    vecs[34] = mk(0, 0, 32'h0,        1, 1, 32'h4,        0, 0, 32'h0,        32'h0);

    // Directed table: one vector per cycle, outputs checked mid-cycle.
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      bus.mispredict  = vecs[i].mp;
      bus.redirect_pc = vecs[i].rpc;
      bus.ready_out   = vecs[i].rdy;
      #2;
      check("imem_req", i, {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
      check("valid_out", i, {31'b0, bus.valid_out}, {31'b0, vecs[i].e_vld});
      if (vecs[i].e_req) check("imem_addr", i, bus.imem_addr, vecs[i].e_addr);
      if (vecs[i].e_vld || vecs[i].chk_dat) begin
        check("pc_out", i, bus.pc_out, vecs[i].e_pc);
        check("instr_out", i, bus.instr_out, vecs[i].e_instr);
      end
    end

    // Stream with irregular decode stalls: every pop must be the next sequential PC.
    begin
      logic [31:0] exp_pc;
      int pops;
      exp_pc = 32'h0;
      pops = 0;
      @(negedge clk);
      reset = 1'b1;
      bus.mispredict = 1'b0;
      bus.ready_out = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
        bus.ready_out = (c % 3 == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
        #2;
        if (bus.valid_out && bus.ready_out) begin
          check("stream_pc", c, bus.pc_out, exp_pc);
          check("stream_instr", c, bus.instr_out, 32'hA0 + exp_pc);
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        @(negedge clk);
      end
      check("stream_min_pops", 0, (pops >= 20) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
